// File: rtl/lc3_ea_sequencer_pkg.sv
// Shared LC-3 constants: opcodes, sequencer state encoding and EA modes.
// Indirect support is selected with LC3_EA_INDIRECT_EN.
package lc3_pkg;

  localparam int WORD_W = 16;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_IND_REQ,
    S_IND_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    EA_PC9,
    EA_PC11,
    EA_BASE,
    EA_BASE6,
    EA_TRAP,
    EA_ILL
  } ea_mode_t;

  typedef struct packed {
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] base;
  } ea_req_t;

endpackage

// File: rtl/lc3_ea_sequencer_if.sv
// Request, result and indirect-read bundle of the EA sequencer.
// slave = sequencer side, master = decode/memory environment side.
interface lc3_ea_sequencer_if;
  import lc3_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [WORD_W-1:0] ir;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] base;

  logic              ea_valid;
  logic              ea_ready;
  logic [WORD_W-1:0] ea;
  logic              err;

  logic              mem_req;
  logic              mem_gnt;
  logic [WORD_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, ir, pc, base,
    input  ea_ready,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready,
    output ea_valid, ea, err,
    output mem_req, mem_addr
  );

  modport master (
    output req_valid, ir, pc, base,
    output ea_ready,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready,
    input  ea_valid, ea, err,
    input  mem_req, mem_addr
  );

endinterface

// File: rtl/lc3_ea_sequencer_sext.sv
// Sign-extends an IN_W-bit offset field to a 16-bit word.
module lc3_sext #(
  parameter int IN_W = 9
) (
  input  logic [IN_W-1:0] din,
  output logic [15:0]     dout
);

  assign dout = {{(16-IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/lc3_ea_sequencer.sv
// LC-3 effective-address sequencer with one shared adder.
// `define LC3_EA_INDIRECT_EN enables the LDI/STI pointer read path.
module lc3_ea_sequencer
  import lc3_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst_n,
  lc3_ea_sequencer_if.slave bus
);

  state_t   state;
  state_t   nxt;
  ea_req_t  q;
  ea_mode_t mode;

  logic [WORD_W-1:0] s6;
  logic [WORD_W-1:0] s9;
  logic [WORD_W-1:0] s11;
  logic [WORD_W-1:0] a_op;
  logic [WORD_W-1:0] b_op;
  logic [WORD_W-1:0] sum;
  logic [WORD_W-1:0] calc_ea;
  logic              calc_err;
  logic [3:0]        op;

  logic [WORD_W-1:0] ea_q;
  logic [WORD_W-1:0] ea_d;
  logic              err_q;
  logic              err_d;
  logic              vld_q;
  logic              vld_d;

`ifdef LC3_EA_INDIRECT_EN
  logic              ind;
  logic              mreq_q;
  logic              mreq_d;
  logic [WORD_W-1:0] maddr_q;
  logic [WORD_W-1:0] maddr_d;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
`else
  logic              unused_mem;
  assign unused_mem = ^{bus.mem_gnt, bus.mem_rvalid,
                        bus.mem_rdata, 8'(MEM_TIMEOUT)};
`endif

  lc3_sext #(.IN_W(6)) u_s6 (
    .din  (q.ir[5:0]),
    .dout (s6)
  );

  lc3_sext #(.IN_W(9)) u_s9 (
    .din  (q.ir[8:0]),
    .dout (s9)
  );

  lc3_sext #(.IN_W(11)) u_s11 (
    .din  (q.ir[10:0]),
    .dout (s11)
  );

  assign op = q.ir[15:12];

  always_comb begin
    mode = EA_ILL;
`ifdef LC3_EA_INDIRECT_EN
    ind  = 1'b0;
`endif
    unique case (1'b1)
      (op == OP_BR), (op == OP_LD),
      (op == OP_ST), (op == OP_LEA):
        mode = EA_PC9;
      (op == OP_LDI), (op == OP_STI): begin
`ifdef LC3_EA_INDIRECT_EN
        mode = EA_PC9;
        ind  = 1'b1;
`else
        mode = EA_ILL;
`endif
      end
      (op == OP_JSR) && q.ir[11]:
        mode = EA_PC11;
      (op == OP_JSR) && !q.ir[11],
      (op == OP_JMP):
        mode = EA_BASE;
      (op == OP_LDR), (op == OP_STR):
        mode = EA_BASE6;
      (op == OP_TRAP):
        mode = EA_TRAP;
      default:
        mode = EA_ILL;
    endcase
  end

  // Single adder; JSRR/JMP pass base through with a zero offset.
  always_comb begin
    a_op = q.pc;
    b_op = '0;
    unique case (mode)
      EA_PC9:   b_op = s9;
      EA_PC11:  b_op = s11;
      EA_BASE:  a_op = q.base;
      EA_BASE6: begin
        a_op = q.base;
        b_op = s6;
      end
      default:  b_op = '0;
    endcase
  end

  assign sum      = a_op + b_op;
  assign calc_err = (mode == EA_ILL);

  always_comb begin
    unique case (mode)
      EA_TRAP: calc_ea = {8'h00, q.ir[7:0]};
      EA_ILL:  calc_ea = '0;
      default: calc_ea = sum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      q     <= '0;
      ea_q  <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
`ifdef LC3_EA_INDIRECT_EN
      mreq_q  <= 1'b0;
      maddr_q <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state <= nxt;
      if (state == S_IDLE && bus.req_valid) begin
        q.ir   <= bus.ir;
        q.pc   <= bus.pc;
        q.base <= bus.base;
      end
      ea_q  <= ea_d;
      err_q <= err_d;
      vld_q <= vld_d;
`ifdef LC3_EA_INDIRECT_EN
      mreq_q  <= mreq_d;
      maddr_q <= maddr_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (bus.req_valid) nxt = S_CALC;
`ifdef LC3_EA_INDIRECT_EN
      S_CALC:
        nxt = ind ? S_IND_REQ : S_DONE;
      S_IND_REQ:
        if (bus.mem_gnt) nxt = S_IND_WAIT;
      S_IND_WAIT:
        if (bus.mem_rvalid || cnt_q == 8'd1)
          nxt = S_DONE;
`else
      S_CALC:
        nxt = S_DONE;
`endif
      S_DONE:
        if (bus.ea_ready) nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ea_d  = ea_q;
    err_d = err_q;
    vld_d = vld_q;
`ifdef LC3_EA_INDIRECT_EN
    mreq_d  = mreq_q;
    maddr_d = maddr_q;
    cnt_d   = cnt_q;
`endif
    unique case (state)
      S_CALC: begin
`ifdef LC3_EA_INDIRECT_EN
        if (ind) begin
          mreq_d  = 1'b1;
          maddr_d = sum;
        end else begin
          ea_d  = calc_ea;
          err_d = calc_err;
          vld_d = 1'b1;
        end
`else
        ea_d  = calc_ea;
        err_d = calc_err;
        vld_d = 1'b1;
`endif
      end
`ifdef LC3_EA_INDIRECT_EN
      S_IND_REQ:
        if (bus.mem_gnt) begin
          mreq_d = 1'b0;
          cnt_d  = 8'(MEM_TIMEOUT);
        end
      // The timeout fires on the edge the counter would reach zero.
      S_IND_WAIT:
        if (bus.mem_rvalid) begin
          ea_d  = bus.mem_rdata;
          err_d = 1'b0;
          vld_d = 1'b1;
        end else if (cnt_q == 8'd1) begin
          ea_d  = '0;
          err_d = 1'b1;
          vld_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
`endif
      S_DONE:
        if (bus.ea_ready) vld_d = 1'b0;
      default: ;
    endcase
  end

  assign bus.req_ready = rst_n && (state == S_IDLE);
  assign bus.ea_valid  = vld_q;
  assign bus.ea        = ea_q;
  assign bus.err       = err_q;

`ifdef LC3_EA_INDIRECT_EN
  assign bus.mem_req   = mreq_q;
  assign bus.mem_addr  = maddr_q;
`else
  assign bus.mem_req   = 1'b0;
  assign bus.mem_addr  = '0;
`endif

endmodule

// File: tb/tb_lc3_ea_sequencer.sv
// Scoreboard bench for lc3_ea_sequencer: directed vectors,
// results checked by a monitor on each ea_valid/ea_ready handshake.
module tb_lc3_ea_sequencer;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mreq_hi = 0;

  logic [16:0] sb[$];
  logic [16:0] exp_v;

  lc3_ea_sequencer_if bus();

  lc3_ea_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] i,
                       input logic [15:0] p,
                       input logic [15:0] b,
                       input logic [15:0] e,
                       input logic er);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    if (n >= 100) chk("req_ready wait", 16'd0, 16'd1);
    bus.ir = i;
    bus.pc = p;
    bus.base = b;
    bus.req_valid = 1'b1;
    sb.push_back({e, er});
    cyc();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(sb.size() == 0 && bus.req_ready === 1'b1)
           && n < 100) begin
      cyc();
      n++;
    end
    if (n >= 100) chk("idle wait", 16'd0, 16'd1);
  endtask

  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) mreq_hi++;
    if (rst_n && bus.ea_valid === 1'b1 && bus.ea_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected result ea=%h", bus.ea);
      end else begin
        exp_v = sb.pop_front();
        chk("ea", bus.ea, exp_v[16:1]);
        chk("err", {15'd0, bus.err}, {15'd0, exp_v[0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.ir = '0;
    bus.pc = '0;
    bus.base = '0;
    bus.ea_ready = 1'b1;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;

    repeat (3) cyc();
    chk("rst req_ready", {15'd0, bus.req_ready}, 16'd0);
    chk("rst ea_valid", {15'd0, bus.ea_valid}, 16'd0);
    chk("rst ea", bus.ea, 16'h0000);
    chk("rst err", {15'd0, bus.err}, 16'd0);
    chk("rst mem_req", {15'd0, bus.mem_req}, 16'd0);
    chk("rst mem_addr", bus.mem_addr, 16'h0000);
    rst_n = 1'b1;
    cyc();
    chk("idle req_ready", {15'd0, bus.req_ready}, 16'd1);

    // LDR with latency check
    issue(16'h607F, 16'h0000, 16'h3000, 16'h2FFF, 1'b0);
    chk("ldr calc no valid", {15'd0, bus.ea_valid}, 16'd0);
    chk("ldr calc busy", {15'd0, bus.req_ready}, 16'd0);
    cyc();
    chk("ldr valid N+2", {15'd0, bus.ea_valid}, 16'd1);
    wait_idle();

    issue(16'h0FFF, 16'h3001, 16'h0000, 16'h3000, 1'b0);
    issue(16'h01FF, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
    issue(16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    issue(16'hE0FF, 16'h3000, 16'h0000, 16'h30FF, 1'b0);
    issue(16'h2100, 16'h3000, 16'h0000, 16'h2F00, 1'b0);
    issue(16'h3005, 16'h1000, 16'h0000, 16'h1005, 1'b0);
    issue(16'h4C00, 16'h3000, 16'h0000, 16'h2C00, 1'b0);
    issue(16'h4BFF, 16'h3000, 16'h0000, 16'h33FF, 1'b0);
    issue(16'h4080, 16'h3000, 16'h5555, 16'h5555, 1'b0);
    issue(16'hC1C0, 16'h3000, 16'hABCD, 16'hABCD, 1'b0);
    issue(16'h7020, 16'h3000, 16'h1000, 16'h0FE0, 1'b0);
    issue(16'hF025, 16'h3000, 16'h0000, 16'h0025, 1'b0);
    issue(16'hF0FF, 16'h3000, 16'h0000, 16'h00FF, 1'b0);
    issue(16'h8000, 16'h3000, 16'h1111, 16'h0000, 1'b1);
    issue(16'hD000, 16'h3000, 16'h1111, 16'h0000, 1'b1);
    issue(16'h5000, 16'h3000, 16'h1111, 16'h0000, 1'b1);
    issue(16'h9000, 16'h3000, 16'h1111, 16'h0000, 1'b1);
    wait_idle();

    // ADD held in DONE with ea_ready low
    bus.ea_ready = 1'b0;
    issue(16'h1000, 16'h3000, 16'h2222, 16'h0000, 1'b1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("hold ea_valid", {15'd0, bus.ea_valid}, 16'd1);
      chk("hold ea", bus.ea, 16'h0000);
      chk("hold err", {15'd0, bus.err}, 16'd1);
      chk("hold req_ready", {15'd0, bus.req_ready}, 16'd0);
      cyc();
    end
    bus.ea_ready = 1'b1;
    wait_idle();

`ifdef LC3_EA_INDIRECT_EN
    issue(16'hA002, 16'h3001, 16'h0000, 16'h4000, 1'b0);
    cyc();
    chk("ldi mem_req", {15'd0, bus.mem_req}, 16'd1);
    chk("ldi mem_addr", bus.mem_addr, 16'h3003);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    cyc();
    bus.mem_rvalid = 1'b0;
    chk("ldi ungnt req", {15'd0, bus.mem_req}, 16'd1);
    chk("ldi ungnt addr1", bus.mem_addr, 16'h3003);
    cyc();
    chk("ldi ungnt addr2", bus.mem_addr, 16'h3003);
    bus.mem_gnt = 1'b1;
    cyc();
    bus.mem_gnt = 1'b0;
    chk("ldi req drop", {15'd0, bus.mem_req}, 16'd0);
    chk("ldi wait no valid", {15'd0, bus.ea_valid}, 16'd0);
    cyc();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 16'h4000;
    cyc();
    bus.mem_rvalid = 1'b0;
    chk("ldi valid R+1", {15'd0, bus.ea_valid}, 16'd1);
    wait_idle();

    // STI timeout
    issue(16'hB000, 16'h2000, 16'h0000, 16'h0000, 1'b1);
    cyc();
    chk("sti mem_addr", bus.mem_addr, 16'h2000);
    bus.mem_gnt = 1'b1;
    cyc();
    bus.mem_gnt = 1'b0;
    for (int k = 1; k < TMO; k++) begin
      cyc();
      chk("tmo early", {15'd0, bus.ea_valid}, 16'd0);
    end
    cyc();
    chk("tmo at limit", {15'd0, bus.ea_valid}, 16'd1);
    wait_idle();

    // reset while in IND_WAIT
    issue(16'hA000, 16'h1000, 16'h0000, 16'h0000, 1'b0);
    cyc();
    bus.mem_gnt = 1'b1;
    cyc();
    bus.mem_gnt = 1'b0;
    cyc();
`else
    // LDI/STI are illegal without the indirect path
    issue(16'hA002, 16'h3001, 16'h0000, 16'h0000, 1'b1);
    issue(16'hB1FF, 16'h3001, 16'h0000, 16'h0000, 1'b1);
    wait_idle();
    chk("no mem_req", mreq_hi[15:0], 16'd0);

    // reset while holding a result
    bus.ea_ready = 1'b0;
    issue(16'hF012, 16'h0000, 16'h0000, 16'h0012, 1'b0);
    cyc();
`endif
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid rst ea_valid", {15'd0, bus.ea_valid}, 16'd0);
    chk("mid rst mem_req", {15'd0, bus.mem_req}, 16'd0);
    chk("mid rst req_ready", {15'd0, bus.req_ready}, 16'd0);
    chk("mid rst ea", bus.ea, 16'h0000);
    cyc();
    rst_n = 1'b1;
    bus.ea_ready = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    cyc();
    bus.mem_rvalid = 1'b0;
    chk("late rvalid valid", {15'd0, bus.ea_valid}, 16'd0);
    chk("late rvalid ready", {15'd0, bus.req_ready}, 16'd1);
    chk("late rvalid ea", bus.ea, 16'h0000);
    issue(16'hC1C0, 16'h0000, 16'h1234, 16'h1234, 1'b0);
    wait_idle();

    chk("leftover", sb.size() > 0 ? 16'd1 : 16'd0, 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
